// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and loader FSM state type for the AES-128 loader.
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORD_W = 32;
  localparam int AES_LATENCY = 21;
  typedef enum logic [1:0] {LOAD_KEY, LOAD_STATE, ISSUE} state_e;
endpackage

// File: rtl/aes_result_fifo.sv
// aes_result_fifo: synchronous result FIFO with occupancy count; data reads as 0 when empty.
module aes_result_fifo import aes_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W = AES_BLOCK_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [W-1:0]                 data_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 data_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pop;
  assign pop = pop_i && cnt_q != '0;
  always_comb begin
    wr_d = push_i ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
  assign valid_o = cnt_q != '0;
  assign data_o = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;
  // the issue credit rule guarantees a slot for every tagged result
  assert property (@(posedge clk) disable iff (rst) !(push_i && cnt_q == CW'(DEPTH)));
endmodule

// File: rtl/aes_128_loader.sv
// aes_128_loader: assembles key/plaintext words, issues blocks to a free-running AES-128 pipeline
// under FIFO credit, and captures tagged results in order. Optional AES_LOADER_KEY_REUSE_EN adds key_reuse.
module aes_128_loader import aes_pkg::*; #(
  parameter int LATENCY = AES_LATENCY,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AES_WORD_W-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
`ifdef AES_LOADER_KEY_REUSE_EN
  input  logic                   key_reuse,
`endif
  output logic [AES_BLOCK_W-1:0] core_state,
  output logic [AES_BLOCK_W-1:0] core_key,
  input  logic [AES_BLOCK_W-1:0] core_out,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam int SW = AES_BLOCK_W - AES_WORD_W;
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [AES_BLOCK_W-1:0] key_q, key_d, pt_q, pt_d, cs_q, cs_d, ck_q, ck_d;
  logic launch_q, launch_d;
  logic [LATENCY-1:0] tag_q, tag_d;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_cnt;
  logic accept, reuse, reuse_word, credit_ok;
`ifdef AES_LOADER_KEY_REUSE_EN
  assign reuse = key_reuse;
`else
  assign reuse = 1'b0;
`endif
  assign in_ready = !rst && state_q != ISSUE;
  assign accept = in_valid && in_ready;
  assign reuse_word = reuse && cnt_q == 3'd0;
  // launch_q covers the cycle before the core samples the new block
  assign credit_ok = $countones({tag_q, launch_q}) + int'(fifo_cnt) < FIFO_DEPTH;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    key_d = key_q;
    pt_d = pt_q;
    cs_d = cs_q;
    ck_d = ck_q;
    launch_d = 1'b0;
    tag_d = {tag_q[LATENCY-2:0], launch_q};
    if (accept) begin
      if (state_q == LOAD_KEY && !reuse_word) key_d = {key_q[SW-1:0], in_data};
      else pt_d = {pt_q[SW-1:0], in_data};
      cnt_d = reuse_word ? 3'd5 : cnt_q + 3'd1;
      state_d = (reuse_word || cnt_q == 3'd3) ? LOAD_STATE : cnt_q == 3'd7 ? ISSUE : state_q;
    end
    if (state_q == ISSUE && credit_ok) begin
      cs_d = pt_q;
      ck_d = key_q;
      launch_d = 1'b1;
      state_d = LOAD_KEY;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_KEY;
      cnt_q <= '0;
      key_q <= '0;
      pt_q <= '0;
      cs_q <= '0;
      ck_q <= '0;
      launch_q <= 1'b0;
      tag_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      key_q <= key_d;
      pt_q <= pt_d;
      cs_q <= cs_d;
      ck_q <= ck_d;
      launch_q <= launch_d;
      tag_q <= tag_d;
    end
  end
  assign core_state = cs_q;
  assign core_key = ck_q;
  aes_result_fifo #(.DEPTH(FIFO_DEPTH), .W(AES_BLOCK_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(tag_q[LATENCY-1]),
    .data_i(core_out),
    .pop_i(out_ready),
    .data_o(out_data),
    .valid_o(out_valid),
    .count_o(fifo_cnt)
  );
endmodule

// File: tb/tb_aes_128_loader.sv
// tb_aes_128_loader: randomized and directed checks of the loader against a behavioural AES-128 model.
module tb_aes_128_loader;
  localparam int LAT = 21;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] in_data = '0;
  logic in_valid = 1'b0, in_ready;
  logic [127:0] core_state, core_key, core_out, out_data;
  logic out_valid, out_ready = 1'b0;
`ifdef AES_LOADER_KEY_REUSE_EN
  logic key_reuse = 1'b0;
`endif
  int cmp = 0, bad = 0, rx_cnt = 0, blocks_done = 0;
  logic [127:0] exp_q[$];
  logic [7:0] sbox [256];
  logic sbox_ready = 1'b0;
  logic [127:0] aes_now;
  logic [127:0] pipe [LAT];

  always #5 clk = ~clk;

  aes_128_loader #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
`ifdef AES_LOADER_KEY_REUSE_EN
    .key_reuse(key_reuse),
`endif
    .core_state(core_state),
    .core_key(core_key),
    .core_out(core_out),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] s [16], k [16], t [16];
    logic [7:0] rc, a0, a1, a2, a3, t0, t1, t2, t3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      s[i] = pt[127-8*i -: 8];
      k[i] = key[127-8*i -: 8];
      s[i] ^= k[i];
    end
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      t0 = sbox[k[13]] ^ rc; t1 = sbox[k[14]]; t2 = sbox[k[15]]; t3 = sbox[k[12]];
      k[0] ^= t0; k[1] ^= t1; k[2] ^= t2; k[3] ^= t3;
      for (int i = 4; i < 16; i++) k[i] ^= k[i-4];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) t[i] = sbox[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= k[i];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  task automatic init_sbox();
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    sbox_ready = 1'b1;
  endtask

  // free-running core: every cycle's inputs emerge LAT cycles after being sampled
  always @(core_state, core_key, sbox_ready) aes_now = aes128(core_key, core_state);
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= aes_now;
  end
  assign core_out = pipe[LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic acc;
    int n;
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1;
    in_data = w;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 400) begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      cmp++; bad++;
      $display("FAIL send_word: in_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic send_block(input logic [127:0] key, input logic [127:0] pt, input int gapmax);
    exp_q.push_back(aes128(key, pt));
    for (int i = 0; i < 4; i++) send_word(key[127-32*i -: 32], int'($urandom_range(gapmax, 0)));
    for (int i = 0; i < 4; i++) send_word(pt[127-32*i -: 32], int'($urandom_range(gapmax, 0)));
    blocks_done++;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    cmp++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic monitor();
    logic hold;
    logic [127:0] hd;
    hold = 1'b0;
    hd = '0;
    forever begin
      @(negedge clk);
      if (rst) hold = 1'b0;
      else begin
        if (hold) begin
          cmp++;
          if (!out_valid || out_data !== hd) begin
            bad++;
            $display("FAIL hold_stable: valid=%0b data=%h, required valid=1 data=%h", out_valid, out_data, hd);
          end
        end
        if (out_valid && out_ready) begin
          cmp++;
          rx_cnt++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL result_order: unexpected data=%h, required no result", out_data);
          end else begin
            if (out_data !== exp_q[0]) begin
              bad++;
              $display("FAIL result_order: data=%h, required %h", out_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
          end
        end
        hold = out_valid && !out_ready;
        hd = out_data;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    cmp += 5;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
    if (core_state !== '0) begin bad++; $display("FAIL reset_core_state: got %h, required 0", core_state); end
    if (core_key !== '0) begin bad++; $display("FAIL reset_core_key: got %h, required 0", core_key); end
    step();
    rst = 1'b0;
    @(negedge clk);
    cmp++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b, required 1", in_ready); end
    step();
  endtask

  task automatic test_fips();
    int n;
    out_ready = 1'b1;
    send_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 0);
    @(negedge clk);
    cmp++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL fips_issue_state: in_ready=%b, required 0", in_ready); end
    step();
    @(negedge clk);
    cmp++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL fips_issued: in_ready=%b, required 1", in_ready); end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    cmp += 2;
    if (n != LAT + 1) begin bad++; $display("FAIL fips_latency: %0d cycles, required %0d", n, LAT + 1); end
    if (out_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a)
      begin bad++; $display("FAIL fips_data: got %h, required 69c4e0d86a7b0430d8cdb78070b4c55a", out_data); end
    step();
    wait_drain(100);
  endtask

  task automatic test_back_to_back();
    logic [127:0] k [6], p [6];
    int rx0;
    for (int b = 0; b < 6; b++) begin
      k[b] = {$urandom, $urandom, $urandom, $urandom};
      p[b] = {$urandom, $urandom, $urandom, $urandom};
    end
    out_ready = 1'b0;
    blocks_done = 0;
    rx0 = rx_cnt;
    fork
      for (int b = 0; b < 6; b++) send_block(k[b], p[b], 0);
      begin
        repeat (150) step();
        @(negedge clk);
        cmp += 3;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready: got %b, required 0", in_ready); end
        if (blocks_done != 5) begin bad++; $display("FAIL b2b_loaded: %0d blocks, required 5", blocks_done); end
        if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %b, required 1", out_valid); end
        step();
        out_ready = 1'b1;
      end
    join
    wait_drain(200);
    cmp++;
    if (rx_cnt - rx0 != 6) begin bad++; $display("FAIL b2b_count: %0d results, required 6", rx_cnt - rx0); end
  endtask

  task automatic test_push_pop();
    int rx0, n;
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) send_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0);
    repeat (60) step();
    send_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0);
    // pop exactly on the edge where the fourth result is pushed
    repeat (LAT + 1) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (3) step();
    rx0 = rx_cnt;
    out_ready = 1'b1;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (!out_valid) break;
      n++;
    end
    cmp++;
    if (n != 3) begin bad++; $display("FAIL push_pop_count: %0d buffered, required 3", n); end
    step();
    wait_drain(50);
    cmp++;
    if (rx_cnt - rx0 != 3) begin bad++; $display("FAIL push_pop_rx: %0d results, required 3", rx_cnt - rx0); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] w;
    logic seen;
    out_ready = 1'b1;
    w = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) send_word(w[127-32*i -: 32], 0);
    for (int i = 0; i < 2; i++) send_word(w[127-32*i -: 32], 0);
    rst = 1'b1;
    @(negedge clk);
    cmp++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready: got %b, required 0", in_ready); end
    step();
    rst = 1'b0;
    @(negedge clk);
    cmp++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_release_ready: got %b, required 1", in_ready); end
    step();
    for (int b = 0; b < 2; b++) send_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0);
    rst = 1'b1;
    repeat (2) step();
    exp_q.delete();
    rst = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    cmp++;
    if (seen !== 1'b0) begin bad++; $display("FAIL stale_result: out_valid=%b after reset, required 0", seen); end
    step();
    send_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0);
    wait_drain(100);
  endtask

  task automatic test_gaps();
    logic [127:0] k [4], p [4];
    int rx0;
    out_ready = 1'b1;
    rx0 = rx_cnt;
    for (int b = 0; b < 4; b++) begin
      k[b] = {$urandom, $urandom, $urandom, $urandom};
      p[b] = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int b = 0; b < 4; b++) send_block(k[b], p[b], 0);
    wait_drain(200);
    for (int b = 0; b < 4; b++) send_block(k[b], p[b], 3);
    wait_drain(200);
    cmp++;
    if (rx_cnt - rx0 != 8) begin bad++; $display("FAIL gaps_count: %0d results, required 8", rx_cnt - rx0); end
  endtask

  task automatic test_random_ready();
    logic stop;
    stop = 1'b0;
    fork
      begin
        for (int b = 0; b < 6; b++) send_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 2);
        stop = 1'b1;
      end
      while (!stop) begin
        out_ready = 1'($urandom_range(1, 0));
        step();
      end
    join
    out_ready = 1'b1;
    wait_drain(300);
  endtask

`ifdef AES_LOADER_KEY_REUSE_EN
  task automatic test_key_reuse();
    logic [127:0] k1, p2;
    out_ready = 1'b1;
    k1 = {$urandom, $urandom, $urandom, $urandom};
    p2 = {$urandom, $urandom, $urandom, $urandom};
    send_block(k1, {$urandom, $urandom, $urandom, $urandom}, 0);
    exp_q.push_back(aes128(k1, p2));
    key_reuse = 1'b1;
    send_word(p2[127:96], 0);
    key_reuse = 1'b0;
    for (int i = 1; i < 4; i++) send_word(p2[127-32*i -: 32], 0);
    send_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1);
    wait_drain(200);
  endtask
`endif

  initial begin
    init_sbox();
    fork
      monitor();
    join_none
    test_reset();
    test_fips();
    test_back_to_back();
    test_push_pop();
    test_reset_mid();
    test_gaps();
    test_random_ready();
`ifdef AES_LOADER_KEY_REUSE_EN
    test_key_reuse();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
